// File: rtl/hazard_scoreboard_ctrl_if.sv
// Decode, write-back and branch signals exchanged between the pipeline and the
// hazard scoreboard controller, plus the controller's decisions and statistics.
interface hazard_scoreboard_ctrl_if #(
  parameter int unsigned PERF_W = 32
);
  logic              id_valid;
  logic [4:0]        id_rn;
  logic [4:0]        id_r2;
  logic              id_use_rn;
  logic              id_use_r2;
  logic [4:0]        id_rd;
  logic              id_reg_write;
  logic              wb_valid;
  logic [4:0]        wb_rd;
  logic              branch_taken;
  logic              id_issue;
  logic              stall;
  logic              flush;
  logic              busy;
  logic [PERF_W-1:0] stall_cycles;
  logic [PERF_W-1:0] flush_count;

  modport master (
    output id_valid, id_rn, id_r2, id_use_rn, id_use_r2, id_rd, id_reg_write,
    output wb_valid, wb_rd, branch_taken,
    input  id_issue, stall, flush, busy, stall_cycles, flush_count
  );

  modport slave (
    input  id_valid, id_rn, id_r2, id_use_rn, id_use_r2, id_rd, id_reg_write,
    input  wb_valid, wb_rd, branch_taken,
    output id_issue, stall, flush, busy, stall_cycles, flush_count
  );
endinterface

// File: rtl/hazard_scoreboard_ctrl.sv
// Decode/execute sequencing controller: per-register pending-write scoreboard,
// RAW / WAW-saturation stalls, taken-branch flush and stall/flush statistics.
module hazard_scoreboard_ctrl #(
  parameter int unsigned NUM_REGS = 32,
  parameter int unsigned CNT_W    = 2,
  parameter int unsigned PERF_W   = 32
) (
  input logic                     clk,
  input logic                     rst_n,
  hazard_scoreboard_ctrl_if.slave io_bus
);
  localparam int unsigned RegW = $clog2(NUM_REGS);
  localparam logic [RegW-1:0] Xzr = RegW'(NUM_REGS - 1);

  logic [CNT_W-1:0]  r_cnt   [NUM_REGS];
  logic [CNT_W-1:0]  w_cnt_d [NUM_REGS];
  logic [PERF_W-1:0] r_stall_cycles, w_stall_cycles_d;
  logic [PERF_W-1:0] r_flush_count, w_flush_count_d;

  logic w_raw, w_waw_full, w_stall, w_flush, w_issue, w_inc, w_dec, w_busy;

  // Hazards look only at registered counts: a same-cycle write-back is not bypassed.
  always_comb begin
    w_raw      = (io_bus.id_use_rn && (r_cnt[io_bus.id_rn] != '0)) ||
                 (io_bus.id_use_r2 && (r_cnt[io_bus.id_r2] != '0));
    w_waw_full = io_bus.id_reg_write && (io_bus.id_rd != Xzr) && (&r_cnt[io_bus.id_rd]);
    w_flush    = rst_n && io_bus.branch_taken;
    w_stall    = rst_n && io_bus.id_valid && !io_bus.branch_taken && (w_raw || w_waw_full);
    w_issue    = rst_n && io_bus.id_valid && !io_bus.branch_taken && !w_raw && !w_waw_full;
    w_inc      = w_issue && io_bus.id_reg_write && (io_bus.id_rd != Xzr);
    w_dec      = io_bus.wb_valid && (io_bus.wb_rd != Xzr);
  end

  always_comb begin
    w_busy = 1'b0;
    for (int r = 0; r < int'(NUM_REGS); r++) begin
      logic w_inc_hit, w_dec_hit;
      w_inc_hit  = w_inc && (io_bus.id_rd == RegW'(r));
      w_dec_hit  = w_dec && (io_bus.wb_rd == RegW'(r));
      w_cnt_d[r] = r_cnt[r];
      if (r == int'(NUM_REGS) - 1) begin
        w_cnt_d[r] = '0;
      end else if (w_inc_hit && !w_dec_hit) begin
        w_cnt_d[r] = r_cnt[r] + CNT_W'(1);
      end else if (w_dec_hit && !w_inc_hit && (r_cnt[r] != '0)) begin
        // Spurious write-back of an idle register leaves it at zero.
        w_cnt_d[r] = r_cnt[r] - CNT_W'(1);
      end
      w_busy = w_busy | (r_cnt[r] != '0);
    end
  end

  always_comb begin
    w_stall_cycles_d = r_stall_cycles;
    w_flush_count_d  = r_flush_count;
    if (w_stall && !(&r_stall_cycles)) w_stall_cycles_d = r_stall_cycles + PERF_W'(1);
    if (w_flush && !(&r_flush_count))  w_flush_count_d  = r_flush_count + PERF_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < int'(NUM_REGS); r++) r_cnt[r] <= '0;
      r_stall_cycles <= '0;
      r_flush_count  <= '0;
    end else begin
      r_cnt          <= w_cnt_d;
      r_stall_cycles <= w_stall_cycles_d;
      r_flush_count  <= w_flush_count_d;
    end
  end

  assign io_bus.id_issue     = w_issue;
  assign io_bus.stall        = w_stall;
  assign io_bus.flush        = w_flush;
  assign io_bus.busy         = rst_n && w_busy;
  assign io_bus.stall_cycles = r_stall_cycles;
  assign io_bus.flush_count  = r_flush_count;
endmodule

// File: tb/tb_hazard_scoreboard_ctrl.sv
// Bench for hazard_scoreboard_ctrl: directed scenarios followed by random traffic,
// all checked against a register-count reference model.
module tb_hazard_scoreboard_ctrl;
  localparam int MaxCnt = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  hazard_scoreboard_ctrl_if #(.PERF_W(32)) bus ();

  hazard_scoreboard_ctrl #(
    .NUM_REGS(32),
    .CNT_W   (2),
    .PERF_W  (32)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .io_bus(bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  int          m_cnt [32];
  logic [31:0] m_stall_cycles;
  logic [31:0] m_flush_count;
  bit          e_issue, e_stall, e_flush, e_busy;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int r = 0; r < 32; r++) m_cnt[r] = 0;
    m_stall_cycles = '0;
    m_flush_count  = '0;
  endtask

  task automatic drive(input bit v, input int rn, input bit urn, input int r2, input bit ur2,
                       input int rd, input bit rw, input bit wv, input int wrd, input bit br);
    bus.id_valid     = v;
    bus.id_rn        = 5'(rn);
    bus.id_use_rn    = urn;
    bus.id_r2        = 5'(r2);
    bus.id_use_r2    = ur2;
    bus.id_rd        = 5'(rd);
    bus.id_reg_write = rw;
    bus.wb_valid     = wv;
    bus.wb_rd        = 5'(wrd);
    bus.branch_taken = br;
  endtask

  // Compare DUT outputs against the model at the falling edge.
  task automatic eval();
    bit raw, wfull;
    @(negedge clk);
    raw   = (bus.id_use_rn && m_cnt[bus.id_rn] != 0) || (bus.id_use_r2 && m_cnt[bus.id_r2] != 0);
    wfull = bus.id_reg_write && bus.id_rd != 5'd31 && m_cnt[bus.id_rd] == MaxCnt;
    e_busy = 1'b0;
    for (int r = 0; r < 32; r++) if (m_cnt[r] != 0) e_busy = 1'b1;
    if (!rst_n) begin
      e_issue = 1'b0; e_stall = 1'b0; e_flush = 1'b0; e_busy = 1'b0;
    end else begin
      e_flush = bus.branch_taken;
      e_stall = bus.id_valid && !bus.branch_taken && (raw || wfull);
      e_issue = bus.id_valid && !bus.branch_taken && !raw && !wfull;
    end
    check("id_issue", 32'(bus.id_issue), 32'(e_issue));
    check("stall", 32'(bus.stall), 32'(e_stall));
    check("flush", 32'(bus.flush), 32'(e_flush));
    check("busy", 32'(bus.busy), 32'(e_busy));
    check("stall_cycles", bus.stall_cycles, rst_n ? m_stall_cycles : 32'd0);
    check("flush_count", bus.flush_count, rst_n ? m_flush_count : 32'd0);
  endtask

  // Advance one clock and apply the specified bookkeeping to the model.
  task automatic tick();
    @(posedge clk);
    if (!rst_n) begin
      model_clear();
    end else begin
      if (e_issue && bus.id_reg_write && bus.id_rd != 5'd31) m_cnt[bus.id_rd]++;
      if (bus.wb_valid && bus.wb_rd != 5'd31 && m_cnt[bus.wb_rd] > 0) m_cnt[bus.wb_rd]--;
      if (e_stall && m_stall_cycles != '1) m_stall_cycles++;
      if (e_flush && m_flush_count != '1) m_flush_count++;
    end
    #1;
  endtask

  task automatic step();
    eval();
    tick();
  endtask

  initial begin
    logic [31:0] saved_stalls;
    int regs [5];
    regs = '{0, 1, 2, 3, 31};
    model_clear();

    // Reset, including a would-be issuing instruction that must be gated.
    rst_n = 1'b0;
    drive(1, 0, 0, 0, 0, 3, 1, 0, 0, 1);
    step();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step();
    rst_n = 1'b1;
    step();
    check("idle_busy", 32'(bus.busy), 32'd0);

    // RAW stall with non-bypassed write-back.
    drive(1, 0, 0, 0, 0, 3, 1, 0, 0, 0);
    step();
    drive(1, 3, 1, 0, 0, 4, 0, 0, 0, 0);
    eval(); check("raw_stall", 32'(bus.stall), 32'd1); tick();
    drive(1, 3, 1, 0, 0, 4, 0, 1, 3, 0);
    eval(); check("raw_wb_stall", 32'(bus.stall), 32'd1); tick();
    drive(1, 3, 1, 0, 0, 4, 0, 0, 0, 0);
    eval();
    check("raw_issue", 32'(bus.id_issue), 32'd1);
    check("raw_stall_cycles", bus.stall_cycles, 32'd2);
    tick();

    // XZR is never tracked.
    drive(1, 0, 0, 0, 0, 31, 1, 0, 0, 0);
    step();
    drive(1, 31, 1, 31, 1, 0, 0, 0, 0, 0);
    eval();
    check("xzr_stall", 32'(bus.stall), 32'd0);
    check("xzr_busy", 32'(bus.busy), 32'd0);
    tick();

    // WAW saturation on r5.
    for (int i = 0; i < 3; i++) begin
      drive(1, 0, 0, 0, 0, 5, 1, 0, 0, 0);
      step();
    end
    check("waw_cnt3", 32'(dut.r_cnt[5]), 32'd3);
    drive(1, 0, 0, 0, 0, 5, 1, 0, 0, 0);
    eval(); check("waw_stall", 32'(bus.stall), 32'd1); tick();
    drive(1, 0, 0, 0, 0, 5, 1, 1, 5, 0);
    eval(); check("waw_wb_stall", 32'(bus.stall), 32'd1); tick();
    drive(1, 0, 0, 0, 0, 5, 1, 0, 0, 0);
    eval(); check("waw_issue", 32'(bus.id_issue), 32'd1); tick();
    check("waw_cnt_back", 32'(dut.r_cnt[5]), 32'd3);
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 0, 0, 0, 0, 0, 1, 5, 0);
      step();
    end

    // Flush has priority over a RAW stall.
    drive(1, 0, 0, 0, 0, 7, 1, 0, 0, 0);
    step();
    saved_stalls = m_stall_cycles;
    drive(1, 7, 1, 0, 0, 8, 1, 0, 0, 1);
    eval();
    check("br_flush", 32'(bus.flush), 32'd1);
    check("br_stall", 32'(bus.stall), 32'd0);
    check("br_issue", 32'(bus.id_issue), 32'd0);
    tick();
    check("br_flush_count", bus.flush_count, 32'd1);
    check("br_stall_cycles", bus.stall_cycles, saved_stalls);
    drive(0, 0, 0, 0, 0, 0, 0, 1, 7, 0);
    step();

    // Simultaneous inc/dec and spurious write-back.
    drive(1, 0, 0, 0, 0, 9, 1, 0, 0, 0);
    step();
    drive(1, 0, 0, 0, 0, 9, 1, 1, 9, 0);
    step();
    check("incdec_cnt9", 32'(dut.r_cnt[9]), 32'd1);
    drive(0, 0, 0, 0, 0, 0, 0, 1, 12, 0);
    step();
    check("spurious_cnt12", 32'(dut.r_cnt[12]), 32'd0);
    drive(0, 0, 0, 0, 0, 0, 0, 1, 9, 0);
    step();
    check("drained_busy", 32'(bus.busy), 32'd0);

    // Random traffic over a few registers, with one mid-run reset.
    for (int i = 0; i < 400; i++) begin
      if (i == 200) rst_n = 1'b0;
      if (i == 202) rst_n = 1'b1;
      drive($urandom_range(0, 3) != 0, regs[$urandom_range(0, 4)], 1'($urandom),
            regs[$urandom_range(0, 4)], 1'($urandom), regs[$urandom_range(0, 4)],
            1'($urandom), 1'($urandom), regs[$urandom_range(0, 4)], $urandom_range(0, 7) == 0);
      step();
    end
    for (int r = 0; r < 4; r++) check("final_cnt", 32'(dut.r_cnt[r]), 32'(m_cnt[r]));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/hazard_scoreboard_ctrl.md
Name: hazard_scoreboard_ctrl

Overview:
- Pipeline sequencing controller between the decode stage and execution stage of the LEGv8 CPU.
- Tracks outstanding register writes in a per-register scoreboard.
- Stalls decode on RAW and WAW-saturation hazards, and flushes IF/ID on a taken branch.
- Decides each cycle whether the decoded instruction advances (issues) into the ID/EX latch; keeps stall and flush statistics.

Parameters:
- NUM_REGS, 32, architectural registers; index 31 is XZR and is never tracked.
- CNT_W, 2, width of each per-register pending-write counter (max 2^CNT_W-1 writes in flight per register).
- PERF_W, 32, width of the stall and flush statistics counters.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- id_valid  input  1  decode stage holds a valid instruction.
- id_rn  input  5  first source register (Instruction[9:5]).
- id_r2  input  5  second source register (Rm or Rt, per Reg2Loc).
- id_use_rn  input  1  instruction reads id_rn.
- id_use_r2  input  1  instruction reads id_r2.
- id_rd  input  5  destination register.
- id_reg_write  input  1  instruction writes id_rd.
- wb_valid  input  1  write-back retires a register write this cycle.
- wb_rd  input  5  register retired by write-back.
- branch_taken  input  1  EX resolved taken branch (PCSrc), single-cycle pulse.
- id_issue  output  1  ID instruction transfers to ID/EX this cycle.
- stall  output  1  hold PC and IF/ID, insert bubble into ID/EX.
- flush  output  1  squash IF/ID contents this cycle.
- busy  output  1  any scoreboard counter nonzero.
- stall_cycles  output  PERF_W  cycles with stall asserted.
- flush_count  output  PERF_W  taken-branch flushes.

Behaviour:
- Reset (async, rst_n low): all counters = 0, stall_cycles = 0, flush_count = 0. id_issue, stall, flush and busy are 0 while in reset.
- Scoreboard: cnt[r] for r in 0..30. cnt[31] is constant 0; reads of register 31 never hazard, and writes to it are never counted.
- Decode outputs are combinational from the current inputs and the registered state:
  - raw = (id_use_rn & cnt[id_rn]!=0) | (id_use_r2 & cnt[id_r2]!=0).
  - waw_full = id_reg_write & id_rd!=31 & cnt[id_rd]==max.
  - flush = branch_taken.
  - stall = id_valid & ~branch_taken & (raw | waw_full).
  - id_issue = id_valid & ~branch_taken & ~raw & ~waw_full.
- Same-cycle write-back does NOT bypass the hazard check: a register retiring this cycle still stalls the reader; the reader issues the next cycle. This gives a fixed 1-cycle write-then-read latency.
- Counter update at the clock edge: inc = id_issue & id_reg_write & id_rd!=31; dec = wb_valid & wb_rd!=31.
  - inc only: cnt+1. dec only: cnt-1. Both to the same register: unchanged. Different registers: each updated independently.
- Decrement of a zero counter (spurious write-back): counter stays 0, never wraps.
- Increment is blocked by waw_full, so the counter never exceeds max.
- Taken branch: flush=1 for exactly the pulse cycle. The ID instruction is not issued and the scoreboard is not incremented for it. Write-back decrements still apply that cycle.
- branch_taken has priority over stall; stall is 0 during flush.
- busy = OR of all cnt != 0, from the registered state.
- stall_cycles increments on each cycle with stall=1; flush_count on each cycle with flush=1. Both saturate at all-ones.
- Reset mid-operation clears all in-flight tracking immediately; the bench must drain the pipeline alongside.
- No internal FSM beyond the scoreboard. Latency: the issue decision is zero-cycle; scoreboard state is visible one cycle after issue.

Test Plan:
- Reset then idle: rst_n low for 2 cycles, id_valid=0 -> all outputs 0, busy=0, counters 0.
- RAW stall: issue ADD rd=3 (reg_write=1); next cycle id_rn=3, id_use_rn=1 -> stall=1, id_issue=0. Apply wb_valid=1, wb_rd=3 -> stall still 1 that cycle. Following cycle id_issue=1 and stall_cycles=2.
- XZR: issue rd=31 writer, then reader of rn=31 -> no stall, busy stays 0.
- WAW saturation (CNT_W=2): issue 3 writers to rd=5 with no write-back -> cnt[5]=3. A 4th writer to rd=5 -> stall=1. Apply wb_rd=5 -> next cycle the 4th writer issues and cnt[5] returns to 3.
- Flush priority: cnt[7]=1, ID reads rn=7, branch_taken=1 -> flush=1, stall=0, id_issue=0, flush_count=1, stall_cycles unchanged.
- Simultaneous inc/dec: cnt[9]=1; issue writer rd=9 while wb_rd=9 -> cnt[9] stays 1. Spurious wb_rd=12 with cnt[12]=0 -> cnt[12] stays 0.
